// File: rtl/piso_transmitter.sv
// piso_transmitter: parallel-in serial-out transmitter.
// Accepts one word through a valid/ready handshake, then shifts it out one
// bit per enable tick. The final bit is flagged with a one-cycle done pulse.
module piso_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  en,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  busy,
  output logic                  done
);

  // A counter of at least one bit keeps DATA_WIDTH=1 legal. It counts only
  // up to DATA_WIDTH-1 inside a word, so it never wraps mid-word.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ser_out_q, ser_out_d;
  logic                  ser_valid_q, ser_valid_d;
  logic                  done_q, done_d;

  logic emit;
  logic last_bit;

  assign emit     = (state_q == SHIFT) && en;
  assign last_bit = (cnt_q == LAST_CNT);

  // State and datapath registers; a low rst at the clock edge wins over everything.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
    end
  end

  // Next state: accept a word in IDLE, return to IDLE on the last emit.
  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)       state_d = SHIFT;
      SHIFT:   if (en && last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the shifter, bit counter and registered serial outputs.
  always_comb begin
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    if (state_q == IDLE) begin
      if (in_valid) begin
        sreg_d = in_data;
        cnt_d  = '0;
      end
    end else if (emit) begin
      ser_valid_d = 1'b1;
      done_d      = last_bit;
      cnt_d       = last_bit ? '0 : cnt_q + CNT_W'(1);
      if (LSB_FIRST != 0) begin
        ser_out_d = sreg_q[0];
        sreg_d    = sreg_q >> 1;
      end else begin
        ser_out_d = sreg_q[DATA_WIDTH-1];
        sreg_d    = sreg_q << 1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = ~in_ready;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_transmitter.sv
// Testbench for piso_transmitter: three instances (8-bit LSB-first, 8-bit
// MSB-first, 1-bit) share one stimulus stream. A word-level reference model
// queues each expected bit; a negedge monitor pops and compares.
module tb_piso_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       en = 1'b0;

  logic [2:0] in_ready, ser_out, ser_valid, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_transmitter #(.DATA_WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .en(en), .ser_out(ser_out[0]),
    .ser_valid(ser_valid[0]), .busy(busy[0]), .done(done[0])
  );

  piso_transmitter #(.DATA_WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .en(en), .ser_out(ser_out[1]),
    .ser_valid(ser_valid[1]), .busy(busy[1]), .done(done[1])
  );

  piso_transmitter #(.DATA_WIDTH(1), .LSB_FIRST(1)) u_one (
    .clk(clk), .rst(rst), .in_data(in_data[0:0]), .in_valid(in_valid),
    .in_ready(in_ready[2]), .en(en), .ser_out(ser_out[2]),
    .ser_valid(ser_valid[2]), .busy(busy[2]), .done(done[2])
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t exp_q2[$];

  // Reference model state, per instance: a word in flight and how many of
  // its bits have gone out; plus what the serial pins should show.
  logic       pending [3];
  logic [7:0] word    [3];
  int         sent    [3];
  logic       held    [3];
  logic       emitted [3];
  logic       mon_en = 1'b0;

  function automatic int dw_of(int i);
    return (i == 2) ? 1 : 8;
  endfunction

  function automatic bit lsb_of(int i);
    return (i != 1);
  endfunction

  // j-th transmitted bit of a word, straight from the bit-order rule.
  function automatic logic pick_bit(logic [7:0] w, int dw, bit lsb, int j);
    return lsb ? w[j] : w[dw-1-j];
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(int i, exp_t e);
    case (i)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(int i, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    case (i)
      0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
      1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Reference model: advance each instance's word-level state on every edge.
  always @(posedge clk) begin
    mon_en <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      emitted[i] = 1'b0;
      if (!rst) begin
        pending[i] = 1'b0;
        sent[i]    = 0;
        held[i]    = 1'b0;
      end else if (!pending[i]) begin
        if (in_valid) begin
          pending[i] = 1'b1;
          word[i]    = (dw_of(i) == 1) ? {7'b0, in_data[0]} : in_data;
          sent[i]    = 0;
        end
      end else if (en) begin
        exp_t e;
        e.b    = pick_bit(word[i], dw_of(i), lsb_of(i), sent[i]);
        e.last = (sent[i] == dw_of(i) - 1);
        push_exp(i, e);
        held[i]    = e.b;
        emitted[i] = 1'b1;
        sent[i]++;
        if (e.last) pending[i] = 1'b0;
      end
    end
  end

  // Monitor: compare every instance's outputs away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("in_ready[%0d]", i), {7'b0, in_ready[i]}, {7'b0, !pending[i]});
        check($sformatf("busy[%0d]", i), {7'b0, busy[i]}, {7'b0, pending[i]});
        check($sformatf("ser_valid[%0d]", i), {7'b0, ser_valid[i]}, {7'b0, emitted[i]});
        if (ser_valid[i] === 1'b1) begin
          bit   ok;
          exp_t e;
          pop_exp(i, ok, e);
          check($sformatf("sb_pop[%0d]", i), {7'b0, ok}, 8'd1);
          if (ok) begin
            check($sformatf("ser_out[%0d]", i), {7'b0, ser_out[i]}, {7'b0, e.b});
            check($sformatf("done[%0d]", i), {7'b0, done[i]}, {7'b0, e.last});
          end
        end else begin
          check($sformatf("done_idle[%0d]", i), {7'b0, done[i]}, 8'd0);
          check($sformatf("ser_out_hold[%0d]", i), {7'b0, ser_out[i]}, {7'b0, held[i]});
        end
      end
    end
  end

  // Apply one cycle of inputs, then step just past the next rising edge.
  task automatic drive(logic r, logic v, logic [7:0] d, logic e);
    rst      = r;
    in_valid = v;
    in_data  = d;
    en       = e;
    @(posedge clk);
    #1;
  endtask

  logic [10:0] stall_pat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      pending[i] = 1'b0;
      word[i]    = '0;
      sent[i]    = 0;
      held[i]    = 1'b0;
      emitted[i] = 1'b0;
    end

    // Reset held across two edges while in_valid and en are high.
    drive(1'b0, 1'b1, 8'hA5, 1'b1);
    drive(1'b0, 1'b1, 8'hA5, 1'b1);

    // Single word 0xA5 with continuous en.
    drive(1'b1, 1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 8'h00, 1'b1);

    // Word 0x81 with a stall pattern on en (first entry applied first).
    drive(1'b1, 1'b1, 8'h81, 1'b0);
    stall_pat = 11'b10111111001;
    for (int k = 0; k < 11; k++) drive(1'b1, 1'b0, 8'h00, stall_pat[k]);
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    // Back-to-back words with in_valid held high; data changes after accept.
    drive(1'b1, 1'b1, 8'h0F, 1'b1);
    for (int k = 0; k < 9; k++) drive(1'b1, 1'b1, 8'hF0, 1'b1);
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset partway through a word, then a clean word 0x01.
    drive(1'b1, 1'b1, 8'hFF, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 2) == 0),
            8'($urandom()),
            ($urandom_range(0, 9) < 7));
    end

    // Drain anything still in flight.
    for (int k = 0; k < 12; k++) drive(1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #1;

    check("sb_drain[0]", 8'(exp_q0.size()), 8'd0);
    check("sb_drain[1]", 8'(exp_q1.size()), 8'd0);
    check("sb_drain[2]", 8'(exp_q2.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
